// File: rtl/student_iic_master_pkg.sv
// rtl/student_iic_master_pkg.sv - shared types for the byte-level I2C master engine
package student_iic_master_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ARB     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ILLEGAL = 2'd3
  } err_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] data;
    logic       nack;
  } cmd_t;

  typedef struct packed {
    logic [7:0] data;
    logic       nack;
    err_e       err;
  } rsp_t;

  function automatic rsp_t mk_rsp(input logic [7:0] data, input logic nack, input err_e err);
    rsp_t r;
    r.data = data;
    r.nack = nack;
    r.err  = err;
    return r;
  endfunction

endpackage

// File: rtl/student_iic_sync.sv
// rtl/student_iic_sync.sv - multi-flop synchronizer for asynchronous pad inputs
module student_iic_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/student_iic_master.sv
// rtl/student_iic_master.sv - I2C master engine: START/STOP/WRITE/READ commands to open-drain pad enables
module student_iic_master
  import student_iic_master_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TO_W        = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  cmd_t             cmd_i,
  output logic             rsp_valid_o,
  output rsp_t             rsp_o,
  output logic             busy_o,
  input  logic             sda_i,
  input  logic             scl_i,
  output logic             sda_oe,
  output logic             scl_oe
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BIT   = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_RSP   = 3'd5;

  // Timeout fires on the hold cycle that would take the wait count to all-ones.
  localparam logic [TO_W-1:0] WAIT_LAST = ~TO_W'(1);

  logic [2:0]       state;
  logic [1:0]       quarter;
  logic [DIV_W-1:0] qcnt;
  logic [DIV_W-1:0] div_q;
  logic [TO_W-1:0]  wcnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  op_e              op_q;
  logic             nack_q;
  logic             ack_nack;
  logic             sda_s;
  logic             scl_s;
  logic             in_phase;
  logic             hold;
  logic             arb_lost;

  student_iic_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sda (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d      (sda_i),
    .q      (sda_s)
  );

  student_iic_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_scl (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d      (scl_i),
    .q      (scl_s)
  );

  assign cmd_ready_o = (state == ST_IDLE);
  assign in_phase    = (state == ST_START) || (state == ST_BIT) ||
                       (state == ST_ACK)   || (state == ST_STOP);
  // A slave stretching SCL freezes the quarter counter while we have released the line.
  assign hold        = in_phase && !scl_oe && !scl_s;
  assign arb_lost    = ((state == ST_START) || ((state == ST_BIT) && (op_q == OP_WRITE))) &&
                       !sda_oe && !sda_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      quarter     <= '0;
      qcnt        <= '0;
      div_q       <= '0;
      wcnt        <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      op_q        <= OP_START;
      nack_q      <= 1'b0;
      ack_nack    <= 1'b0;
      sda_oe      <= 1'b0;
      scl_oe      <= 1'b0;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_o       <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            op_q     <= cmd_i.op;
            nack_q   <= cmd_i.nack;
            div_q    <= clk_div_i;
            qcnt     <= clk_div_i;
            quarter  <= '0;
            wcnt     <= '0;
            bit_cnt  <= 3'd7;
            shreg    <= cmd_i.data;
            ack_nack <= 1'b0;
            if (cmd_i.op == OP_START) begin
              state  <= ST_START;
              scl_oe <= 1'b1;
              sda_oe <= 1'b0;
            end else if (!busy_o) begin
              rsp_o       <= mk_rsp(8'h00, 1'b0, ERR_ILLEGAL);
              rsp_valid_o <= 1'b1;
              state       <= ST_RSP;
            end else if (cmd_i.op == OP_STOP) begin
              state  <= ST_STOP;
              scl_oe <= 1'b1;
              sda_oe <= 1'b1;
            end else begin
              state  <= ST_BIT;
              scl_oe <= 1'b1;
              sda_oe <= (cmd_i.op == OP_WRITE) && !cmd_i.data[7];
            end
          end
        end

        ST_RSP: begin
          state <= ST_IDLE;
        end

        default: begin
          if (hold) begin
            if (wcnt == WAIT_LAST) begin
              sda_oe      <= 1'b0;
              scl_oe      <= 1'b0;
              busy_o      <= 1'b0;
              rsp_o       <= mk_rsp(8'h00, 1'b0, ERR_TIMEOUT);
              rsp_valid_o <= 1'b1;
              state       <= ST_RSP;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end else if (qcnt != '0) begin
            wcnt <= '0;
            qcnt <= qcnt - 1'b1;
          end else begin
            wcnt    <= '0;
            qcnt    <= div_q;
            quarter <= quarter + 1'b1;
            case (quarter)
              2'd0: scl_oe <= 1'b0;
              2'd1: begin
                // SCL has been high for a full quarter here, so SDA is settled.
                if (arb_lost) begin
                  sda_oe      <= 1'b0;
                  scl_oe      <= 1'b0;
                  busy_o      <= 1'b0;
                  rsp_o       <= mk_rsp(8'h00, 1'b0, ERR_ARB);
                  rsp_valid_o <= 1'b1;
                  state       <= ST_RSP;
                end else begin
                  case (state)
                    ST_START: sda_oe   <= 1'b1;
                    ST_BIT:   shreg    <= {shreg[6:0], sda_s};
                    ST_ACK:   ack_nack <= sda_s;
                    default:  sda_oe   <= 1'b0;
                  endcase
                end
              end
              2'd2: begin
                if (state != ST_STOP) begin
                  scl_oe <= 1'b1;
                end
              end
              default: begin
                case (state)
                  ST_START: begin
                    busy_o      <= 1'b1;
                    rsp_o       <= mk_rsp(8'h00, 1'b0, ERR_OK);
                    rsp_valid_o <= 1'b1;
                    state       <= ST_RSP;
                  end
                  ST_BIT: begin
                    if (bit_cnt == 3'd0) begin
                      state  <= ST_ACK;
                      sda_oe <= (op_q == OP_READ) && !nack_q;
                    end else begin
                      bit_cnt <= bit_cnt - 1'b1;
                      sda_oe  <= (op_q == OP_WRITE) && !shreg[7];
                    end
                  end
                  ST_ACK: begin
                    if (op_q == OP_READ) begin
                      rsp_o <= mk_rsp(shreg, nack_q, ERR_OK);
                    end else begin
                      rsp_o <= mk_rsp(8'h00, ack_nack, ERR_OK);
                    end
                    rsp_valid_o <= 1'b1;
                    state       <= ST_RSP;
                  end
                  default: begin
                    busy_o      <= 1'b0;
                    rsp_o       <= mk_rsp(8'h00, 1'b0, ERR_OK);
                    rsp_valid_o <= 1'b1;
                    state       <= ST_RSP;
                  end
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/student_iic_master.md
Name: student_iic_master

Overview:
- Byte-level I2C master engine that replaces CPU bit-banging of SDA/SCL with a hardware state machine.
- Accepts START/STOP/WRITE/READ commands over a valid/ready handshake and returns one response per command.
- Drives open-drain pad enables; an oe of 1 pulls the line low.
- A later TL-UL register wrapper feeds cmd/rsp; this block contains no bus logic.

Parameters:
- DIV_W, 16, width of the quarter-period divider input.
- SYNC_STAGES, 2, number of synchronizer flops on sda_i/scl_i (>=2).
- TO_W, 20, width of the clock-stretch timeout counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clk_div_i  in  DIV_W  quarter SCL period = clk_div_i+1 cycles; sampled at command accept.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  engine idle, can accept.
- cmd_i  in  student_iic_master_pkg::cmd_t  {op[1:0], data[7:0], nack}; nack=1 means master NACKs after READ.
- rsp_valid_o  out  1  one-cycle pulse, one per accepted command.
- rsp_o  out  student_iic_master_pkg::rsp_t  {data[7:0], nack, err[1:0]}.
- busy_o  out  1  bus owned (between START and STOP/error).
- sda_i, scl_i  in  1  raw pad inputs, asynchronous.
- sda_oe, scl_oe  out  1  1 = drive line low, 0 = release.

Behaviour:
- Reset values: sda_oe=0, scl_oe=0, rsp_valid_o=0, rsp_o=0, busy_o=0, cmd_ready_o=1; synchronizer flops reset to 1 (idle bus).
- Handshake: accept when cmd_valid_i && cmd_ready_o; cmd_ready_o=1 only in IDLE; cmd_i and clk_div_i latched on accept.
- Quarter tick: counter loads clk_div_i on each quarter start and counts to 0. Every bus phase is 4 quarters, Q0..Q3. Outputs change only at quarter boundaries.
- Clock stretching: in any quarter where SCL is released, the tick counter is held until synced SCL reads 1.
  - A wait counter runs during the hold. At 2^TO_W-1: err=2 (timeout), both oe=0, busy_o=0, rsp, IDLE.
- States: IDLE, START, BIT, ACK, STOP, RSP.
- START (legal always; repeated start if busy_o=1):
  - Q0: scl_oe=1, sda_oe=0.
  - Q1: scl_oe=0, wait for SCL high.
  - Q2: sda_oe=1.
  - Q3: scl_oe=1.
  - Then busy_o=1, rsp err=0.
- BIT, 8 bits MSB first:
  - Q0: scl_oe=1; sda_oe=~bit for WRITE, 0 for READ.
  - Q1: release SCL, stretch wait.
  - Q2: sample synced SDA into shift register.
  - Q3: scl_oe=1.
- ACK bit (same 4 quarters):
  - WRITE: SDA released; sampled 1 gives rsp nack=1.
  - READ: sda_oe=~nack.
- Arbitration: during a WRITE or START with SDA released, sampled SDA=0 in Q2 means err=1 (arb lost): release both lines, busy_o=0, rsp, IDLE.
- STOP:
  - Q0: scl_oe=1, sda_oe=1.
  - Q1: release SCL, wait high.
  - Q2: sda_oe=0.
  - Q3: idle hold.
  - Then busy_o=0.
- Illegal command: WRITE/READ/STOP with busy_o=0 gives err=3 and rsp on the cycle after accept; no pin activity.
- RSP: rsp_valid_o pulses 1 cycle, rsp_o held until the next rsp. READ returns data; WRITE returns data=0.
- Reset mid-operation: all outputs return to their reset values immediately (async); any in-flight command is dropped with no rsp.

Decomposition:
- Package student_iic_master_pkg:
  - op_e: START=0, STOP=1, WRITE=2, READ=3.
  - err_e: OK=0, ARB=1, TIMEOUT=2, ILLEGAL=3.
  - cmd_t and rsp_t structs.
- Sub-module student_iic_sync: parametrised SYNC_STAGES flop chain with a RESET_VAL parameter; instantiated twice.

Test Plan:
- Reset, then WRITE with busy_o=0 -> rsp err=3 one cycle after accept; sda_oe=scl_oe=0 throughout.
- clk_div_i=3, START -> WRITE 0xA5 against an ACKing slave model -> STOP:
  - SDA bit pattern 1,0,1,0,0,1,0,1 captured on SCL rising edges.
  - WRITE rsp: nack=0, err=0.
  - Each quarter lasts 4 cycles plus the sync delay in Q1.
  - busy_o falls after STOP.
- READ with nack=1, slave drives 0x3C -> rsp data=0x3C; SDA released during the ACK bit.
- Slave holds SCL low 200 cycles in bit 3, TO_W=20 -> transfer completes with the bit stretched, rsp err=0.
- Slave holds SCL low forever, TO_W=8 -> err=2 after 255 wait cycles; both oe=0; busy_o=0.
- WRITE 0xFF while another master pulls SDA low at bit 0 -> err=1; lines released; cmd_ready_o=1 the cycle after the rsp.
